// File: rtl/wrr_packet_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
// Vectors are handled at a fixed maximum width and cast at the use site.
package wrr_arb_pkg;

    localparam int MAXN = 32;

    typedef logic [MAXN-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Lowest set bit of (mask & req), falling back to lowest set bit of req.
    function automatic vec_t rr_first(vec_t mask, vec_t req);
        vec_t sel;
        sel = mask & req;
        if (sel == '0)
            sel = req;
        return sel & (~sel + vec_t'(1));
    endfunction

    function automatic logic [4:0] onehot_to_idx(vec_t oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAXN; i++)
            if (oh[i])
                idx = 5'(i);
        return idx;
    endfunction

endpackage

// File: rtl/wrr_packet_arbiter_if.sv
// Requester-side and output-side valid/ready channel of the arbiter.
// master is the arbiter view, slave is the sources/sink view.
interface wrr_packet_arbiter_if #(
    parameter int nReq = 4,
    parameter int DW   = 32
);
    logic [nReq-1:0]    req_valid;
    logic [nReq-1:0]    req_last;
    logic [nReq*DW-1:0] req_data;
    logic [nReq-1:0]    req_ready;
    logic               out_valid;
    logic               out_last;
    logic [DW-1:0]      out_data;
    logic               out_ready;

    modport master (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_last, out_data
    );

    modport slave (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_last, out_data
    );
endinterface

// File: rtl/wrr_packet_arbiter_rr_pick.sv
// Combinational round-robin pick: masked lowest request, else lowest.
// Produces both the one-hot winner and its index.
module wrr_rr_pick
    import wrr_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    assign grant = N'(rr_first(vec_t'(mask), vec_t'(req)));
    assign idx   = IW'(onehot_to_idx(vec_t'(grant)));

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter with packet lock on one valid/ready channel.
// Define ARB_WEIGHT_EN to add cfg_weight; otherwise credit is fixed at 1.
module wrr_packet_arbiter
    import wrr_arb_pkg::*;
#(
    parameter  int nReq = 4,
    parameter  int DW   = 32,
    parameter  int WW   = 4,
    localparam int IW   = $clog2(nReq)
) (
    input  logic                 clock,
    input  logic                 reset,
    wrr_packet_arbiter_if.master bus,
`ifdef ARB_WEIGHT_EN
    input  logic [nReq*WW-1:0]   cfg_weight,
`endif
    output logic [IW-1:0]        out_idx,
    output logic                 busy
);

    state_t          state;
    logic [IW-1:0]   owner;
    logic [WW-1:0]   credit;
    logic            mid_pkt;
    logic [nReq-1:0] mask;

    logic [nReq-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            any_req;
    logic [WW-1:0]   load_credit;
    logic            own_valid;
    logic            xfer;
    logic            last_xfer;
    logic            release_now;
    logic [nReq-1:0] rel_mask;

    wrr_rr_pick #(.N(nReq)) u_pick (
        .mask  (mask),
        .req   (bus.req_valid),
        .grant (win_oh),
        .idx   (win_idx)
    );

    assign any_req = |win_oh;

`ifdef ARB_WEIGHT_EN
    logic [WW-1:0] w_sel;
    assign w_sel       = cfg_weight[win_idx*WW +: WW];
    assign load_credit = (w_sel == '0) ? WW'(1) : w_sel;
`else
    assign load_credit = WW'(1);
`endif

    assign own_valid = bus.req_valid[owner];
    assign xfer      = (state == GRANT) && own_valid && bus.out_ready;
    assign last_xfer = xfer && bus.req_last[owner];

    // A turn ends on the final credited packet, or when the owner goes
    // quiet between packets and gives up whatever credit is left.
    assign release_now = (state == GRANT) &&
        ((last_xfer && credit == WW'(1)) ||
         (!mid_pkt && credit != '0 && !own_valid));

    assign out_idx = owner;

    // Priority after release starts just above the releasing owner.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < nReq; i++)
            rel_mask[i] = (i > int'(owner));
    end

    // Owner's channel is muxed straight through while the turn is held.
    always_comb begin
        bus.req_ready = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        if (state == GRANT) begin
            bus.req_ready[owner] = bus.out_ready;
            bus.out_valid        = own_valid;
            bus.out_last         = bus.req_last[owner];
            bus.out_data         = bus.req_data[owner*DW +: DW];
        end
    end

    // Arbitration FSM: pick in IDLE, hold ownership and spend credit in GRANT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            credit  <= '0;
            mid_pkt <= 1'b0;
            mask    <= '0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= win_idx;
                        credit  <= load_credit;
                        mid_pkt <= 1'b0;
                        state   <= GRANT;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (xfer)
                        mid_pkt <= !bus.req_last[owner];
                    if (last_xfer)
                        credit <= credit - WW'(1);
                    if (release_now) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mask    <= rel_mask;
                        mid_pkt <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed bench for wrr_packet_arbiter (4 requesters, 32-bit data).
// Expectations follow the ARB_WEIGHT_EN setting of the build.
module tb_wrr_packet_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] out_idx;
    logic       busy;
`ifdef ARB_WEIGHT_EN
    logic [15:0] cfg_weight;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    wrr_packet_arbiter_if #(.nReq(4), .DW(32)) bus ();

    wrr_packet_arbiter #(.nReq(4), .DW(32), .WW(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.master),
`ifdef ARB_WEIGHT_EN
        .cfg_weight (cfg_weight),
`endif
        .out_idx    (out_idx),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_oval"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rrdy"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic grant_chk(input string tag, input int idx);
        logic [3:0] rr;
        rr = '0;
        rr[idx] = bus.out_ready;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_rrdy"}, 32'(bus.req_ready), 32'(rr));
        check({tag, "_data"}, bus.out_data, 32'hD0 + 32'(idx));
    endtask

    int seq2[4] = '{1, 3, 1, 3};
    int seq3[$];
    logic v2 [7] = '{1, 1, 0, 1, 1, 1, 1};
    logic rd [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic ls [7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        bus.out_ready = 1'b1;
`ifdef ARB_WEIGHT_EN
        cfg_weight = 16'h1111;
`endif
        nxt();
        nxt();
        reset = 1'b0;

        // 1: quiet after reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            idle_chk("t1");
            check("t1_idx", 32'(out_idx), 32'd0);
            nxt();
        end

        // 2: requesters 1 and 3 alternate with one idle cycle between
        bus.req_valid = 4'b1010;
        bus.req_last  = 4'b1111;
        foreach (seq2[k]) begin
            @(negedge clock);
            idle_chk("t2_gap");
            nxt();
            @(negedge clock);
            grant_chk("t2", seq2[k]);
            check("t2_oval", 32'(bus.out_valid), 32'd1);
            check("t2_olast", 32'(bus.out_last), 32'd1);
            nxt();
        end
        bus.req_valid = '0;

        // 3: all requesters busy, one rotation
`ifdef ARB_WEIGHT_EN
        cfg_weight = 16'h1131;
        seq3 = '{-1, 0, -1, 1, 1, 1, -1, 2, -1, 3};
`else
        seq3 = '{-1, 0, -1, 1, -1, 2, -1, 3};
`endif
        bus.req_valid = 4'b1111;
        foreach (seq3[k]) begin
            @(negedge clock);
            if (seq3[k] < 0)
                idle_chk("t3_gap");
            else
                grant_chk("t3", seq3[k]);
            nxt();
        end
        bus.req_valid = '0;

        // 4: requester 2 holds a 4-beat packet against requester 0
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        @(negedge clock);
        idle_chk("t4_pre");
        nxt();
        @(negedge clock);
        grant_chk("t4_pre", 1);
        nxt();
        bus.req_valid = 4'b0101;
        bus.req_last  = 4'b0000;
        @(negedge clock);
        idle_chk("t4_gap");
        nxt();
        for (int k = 0; k < 7; k++) begin
            bus.req_valid = {1'b0, v2[k], 1'b0, 1'b1};
            bus.req_last  = {1'b0, ls[k], 2'b00};
            bus.out_ready = rd[k];
            @(negedge clock);
            grant_chk("t4", 2);
            check("t4_oval", 32'(bus.out_valid), 32'(v2[k]));
            nxt();
        end
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        bus.out_ready = 1'b1;
        @(negedge clock);
        idle_chk("t4_rel");
        nxt();
        @(negedge clock);
        grant_chk("t4_next", 0);
        nxt();

        // 5: requester 1 sends one packet then goes quiet
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0010;
        @(negedge clock);
        idle_chk("t5_gap");
        nxt();
        @(negedge clock);
        grant_chk("t5", 1);
        check("t5_oval", 32'(bus.out_valid), 32'd1);
        nxt();
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
`ifdef ARB_WEIGHT_EN
        @(negedge clock);
        grant_chk("t5_forfeit", 1);
        check("t5_oval0", 32'(bus.out_valid), 32'd0);
        nxt();
`endif
        @(negedge clock);
        idle_chk("t5_rel");
        nxt();
        @(negedge clock);
        grant_chk("t5_next", 3);
        check("t5_olast", 32'(bus.out_last), 32'd0);
        nxt();

        // 6: reset while requester 3 is mid-packet
        reset = 1'b1;
        @(negedge clock);
        grant_chk("t6_pre", 3);
        nxt();
        reset = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b1001;
        @(negedge clock);
        idle_chk("t6_rst");
        check("t6_idx", 32'(out_idx), 32'd0);
        nxt();
        @(negedge clock);
        grant_chk("t6_win", 0);
        nxt();
        bus.req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
